// File: rtl/noc_vc_buffer.sv
// Virtual-channel buffer between a core bridge and a NoC router port: per-VC TX and RX FIFOs,
// round-robin TX issue under router flow control, and show-ahead round-robin RX delivery.
`ifndef FLIT_WIDTH
`define FLIT_WIDTH 32
`endif

module noc_vc_buffer #(
    parameter int FLIT_WIDTH = `FLIT_WIDTH,
    parameter int NUM_VCS    = 2,
    parameter int DEPTH      = 4,
    parameter int VC_W       = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  tx_valid,
    input  logic [VC_W-1:0]       tx_vc,
    input  logic [FLIT_WIDTH-1:0] tx_flit,
    output logic [NUM_VCS-1:0]    tx_full_vcs,
    output logic                  noc_en_put,
    output logic [VC_W-1:0]       noc_put_vc,
    output logic [FLIT_WIDTH-1:0] noc_put_flit,
    input  logic [NUM_VCS-1:0]    noc_get_non_full_vcs,
    input  logic                  noc_get_valid,
    input  logic [VC_W-1:0]       noc_get_vc,
    input  logic [FLIT_WIDTH-1:0] noc_get_flit,
    output logic [NUM_VCS-1:0]    noc_put_non_full_vcs,
    output logic                  rx_valid,
    output logic [VC_W-1:0]       rx_vc,
    output logic [FLIT_WIDTH-1:0] rx_flit,
    input  logic                  rx_ready,
    output logic                  err_overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [FLIT_WIDTH-1:0] tx_mem [NUM_VCS][DEPTH];
    logic [FLIT_WIDTH-1:0] rx_mem [NUM_VCS][DEPTH];
    logic [PW-1:0]         tx_rd  [NUM_VCS];
    logic [PW-1:0]         tx_wr  [NUM_VCS];
    logic [PW-1:0]         rx_rd  [NUM_VCS];
    logic [PW-1:0]         rx_wr  [NUM_VCS];
    logic [CW-1:0]         tx_cnt [NUM_VCS];
    logic [CW-1:0]         rx_cnt [NUM_VCS];
    logic [VC_W-1:0]       rr_tx;
    logic [VC_W-1:0]       rr_rx;

    logic [NUM_VCS-1:0]    tx_push_vec;
    logic [NUM_VCS-1:0]    tx_pop_vec;
    logic [NUM_VCS-1:0]    rx_push_vec;
    logic [NUM_VCS-1:0]    rx_pop_vec;
    logic                  tx_any;
    logic [VC_W-1:0]       tx_gvc;
    logic [FLIT_WIDTH-1:0] tx_head;
    logic                  overflow_hit;

    function automatic int rr_idx(input logic [VC_W-1:0] base, input int k);
        return (int'(base) + k) % NUM_VCS;
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_VCS; i++) begin
            tx_full_vcs[i]          = (tx_cnt[i] == CW'(DEPTH));
            noc_put_non_full_vcs[i] = (rx_cnt[i] <= CW'(DEPTH - 2));
        end
    end

    // TX arbiter: first VC at or after rr_tx with data and router space.
    always_comb begin
        tx_any  = 1'b0;
        tx_gvc  = '0;
        tx_head = '0;
        for (int k = 0; k < NUM_VCS; k++) begin
            if (!tx_any && tx_cnt[rr_idx(rr_tx, k)] != '0 && noc_get_non_full_vcs[rr_idx(rr_tx, k)]) begin
                tx_any  = 1'b1;
                tx_gvc  = VC_W'(rr_idx(rr_tx, k));
                tx_head = tx_mem[rr_idx(rr_tx, k)][tx_rd[rr_idx(rr_tx, k)]];
            end
        end
    end

    always_comb begin
        rx_valid = 1'b0;
        rx_vc    = '0;
        rx_flit  = '0;
        for (int k = 0; k < NUM_VCS; k++) begin
            if (!rx_valid && rx_cnt[rr_idx(rr_rx, k)] != '0) begin
                rx_valid = 1'b1;
                rx_vc    = VC_W'(rr_idx(rr_rx, k));
                rx_flit  = rx_mem[rr_idx(rr_rx, k)][rx_rd[rr_idx(rr_rx, k)]];
            end
        end
    end

    // A full RX FIFO still accepts a push when its head leaves on the same edge.
    always_comb begin
        overflow_hit = 1'b0;
        for (int i = 0; i < NUM_VCS; i++) begin
            tx_push_vec[i] = tx_valid && (tx_vc == VC_W'(i)) && !tx_full_vcs[i];
            tx_pop_vec[i]  = tx_any && (tx_gvc == VC_W'(i));
            rx_pop_vec[i]  = rx_valid && rx_ready && (rx_vc == VC_W'(i));
            rx_push_vec[i] = noc_get_valid && (noc_get_vc == VC_W'(i))
                             && ((rx_cnt[i] != CW'(DEPTH)) || rx_pop_vec[i]);
            if (noc_get_valid && (noc_get_vc == VC_W'(i)) && !rx_push_vec[i])
                overflow_hit = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_VCS; i++) begin
                tx_rd[i]  <= '0;
                tx_wr[i]  <= '0;
                rx_rd[i]  <= '0;
                rx_wr[i]  <= '0;
                tx_cnt[i] <= '0;
                rx_cnt[i] <= '0;
            end
            rr_tx        <= '0;
            rr_rx        <= '0;
            noc_en_put   <= 1'b0;
            noc_put_vc   <= '0;
            noc_put_flit <= '0;
            err_overflow <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_VCS; i++) begin
                if (tx_push_vec[i]) tx_wr[i] <= tx_wr[i] + 1'b1;
                if (tx_pop_vec[i])  tx_rd[i] <= tx_rd[i] + 1'b1;
                if (rx_push_vec[i]) rx_wr[i] <= rx_wr[i] + 1'b1;
                if (rx_pop_vec[i])  rx_rd[i] <= rx_rd[i] + 1'b1;
                tx_cnt[i] <= tx_cnt[i] + CW'(tx_push_vec[i]) - CW'(tx_pop_vec[i]);
                rx_cnt[i] <= rx_cnt[i] + CW'(rx_push_vec[i]) - CW'(rx_pop_vec[i]);
            end
            noc_en_put <= tx_any;
            if (tx_any) begin
                noc_put_vc   <= tx_gvc;
                noc_put_flit <= tx_head;
                rr_tx        <= (tx_gvc == VC_W'(NUM_VCS - 1)) ? '0 : tx_gvc + 1'b1;
            end
            if (rx_valid && rx_ready)
                rr_rx <= (rx_vc == VC_W'(NUM_VCS - 1)) ? '0 : rx_vc + 1'b1;
            if (overflow_hit)
                err_overflow <= 1'b1;
        end
    end

    // NOTE: storage arrays are deliberately not reset; pointers and counts define validity.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_VCS; i++) begin
            if (tx_push_vec[i]) tx_mem[i][tx_wr[i]] <= tx_flit;
            if (rx_push_vec[i]) rx_mem[i][rx_wr[i]] <= noc_get_flit;
        end
    end

endmodule
